udcounter_tc_logger: RTL and testbench
======================================

// Module: udcounter_tc_logger
// PURPOSE
//  Downstream stage of the 8-bit up/down counter: consumes its count/tc outputs,
//  detects each terminal-count event and logs it with a timestamp.
//  Each entry holds the direction and the cycle stamp. Entries are buffered in a
//  small FIFO and drained by a valid/ready consumer such as a status reader or
//  an interrupt block.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, >= 2
//  STAMP_W  16  free-running timestamp width (bits)
// PORTS
//  clk        in   1          clock, all logic on posedge
//  reset      in   1          reset, synchronous, active-high; clock clk
//  count      in   8          counter value (same clk domain)
//  tc         in   1          counter terminal-count flag
//  clr_ovf    in   1          clears sticky overflow
//  out_valid  out  1          head entry available
//  out_ready  in   1          consumer accepts head entry
//  out_data   out  STAMP_W+1  {dir, stamp}; dir 0 = up (count==8'hFF), 1 = down
//  level      out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  overflow   out  1          sticky: an event was dropped while full
// BEHAVIOUR
//  - Reset: stamp=0, tc_q=0, FIFO empty, out_valid=0, out_data=0, level=0,
//    overflow=0. Reset mid-operation discards all entries; no pop is reported.
//  - stamp: STAMP_W-bit counter, +1 every cycle, wraps 2^STAMP_W-1 -> 0.
//  - tc_q: tc registered each cycle.
//  - event: tc==1 && tc_q==0, i.e. a rising edge of tc.
//    A tc held high (counter disabled at terminal) gives one event only.
//  - Record: dir = (count==8'h00), evaluated in the event cycle. stamp = value in
//    the event cycle.
//  - Latency: event sampled at edge N -> entry written at edge N.
//    If FIFO was empty, out_valid=1 after edge N with that entry.
//  - Pop when out_valid && out_ready. out_data is the head entry, from registered
//    storage. out_data holds steady while out_valid && !out_ready.
//  - Push when event && (level<DEPTH || pop). Full plus simultaneous pop: both
//    occur, level unchanged.
//  - Drop when event && level==DEPTH && !pop. overflow<=1; FIFO unchanged.
//  - overflow: cleared by clr_ovf. A drop in the same cycle as clr_ovf wins
//    (overflow=1).
//  - Pointers: $clog2(DEPTH) bits, wrap naturally. level = wr_cnt - rd_cnt using
//    extra-bit pointers.
//  - Empty plus event: no same-cycle bypass. out_valid rises the cycle after.
//  - No state machine beyond the FIFO. No combinational path from inputs to outputs.
// CONFIGURATION
//  TC_LOGGER_DROP_CNT_EN defined: adds output drop_cnt [7:0].
//    - Counts dropped events.
//    - Saturates at 8'hFF.
//    - Cleared by reset and by clr_ovf. A drop in the clr_ovf cycle leaves drop_cnt=1.
//  Undefined: no drop_cnt port, no counter logic; overflow only.
// TESTING
//  1 Reset, then tc rises at stamp 5, count=8'hFF, out_ready=0
//    -> next cycle out_valid=1, out_data={0,16'd5}, level=1.
//  2 tc held high 10 cycles, count=8'h00 -> exactly one entry, {1,stamp_at_rise};
//    level=1.
//  3 DEPTH+1 events, no pops -> level=4, overflow=1, entries in order;
//    drop_cnt=1 when EN defined.
//  4 FIFO full, event and out_ready=1 in same cycle -> level stays 4;
//    head is replaced by the next entry; overflow unchanged.
//  5 Stamp wrap: event at stamp 16'hFFFF, next event 3 cycles later
//    -> entries stamp FFFF then 0002.
//  6 Reset asserted with level=3 -> next cycle out_valid=0, level=0, overflow=0.
//    clr_ovf with a simultaneous drop -> overflow stays 1.

Source files
------------

// File: rtl/udcounter_tc_logger.sv
// Terminal-count event logger: timestamps each rising edge of tc and queues {dir, stamp} in a small FIFO.
// Optional feature macro: TC_LOGGER_DROP_CNT_EN adds a saturating drop counter output drop_cnt.
module udcounter_tc_logger #(
    parameter int DEPTH   = 4,
    parameter int STAMP_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               count,
    input  logic                     tc,
    input  logic                     clr_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [STAMP_W:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef TC_LOGGER_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]        PTR_ONE   = (AW+1)'(1);
    localparam logic [STAMP_W-1:0] STAMP_ONE = STAMP_W'(1);

    logic [STAMP_W-1:0] stamp;
    logic               tc_q;
    logic [STAMP_W:0]   mem [DEPTH];
    logic [AW:0]        wr_cnt;
    logic [AW:0]        rd_cnt;

    logic               tc_event;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [STAMP_W:0]   entry;

    // Handshake: the head entry is transferred on any rising clk edge where
    // out_valid && out_ready; out_valid never depends on out_ready and
    // out_data holds steady while out_valid && !out_ready.
    assign level     = wr_cnt - rd_cnt;
    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_cnt[AW-1:0]] : '0;

    assign tc_event = tc && !tc_q;
    assign pop      = out_valid && out_ready;
    assign push     = tc_event && (!full || pop);
    assign drop     = tc_event && full && !pop;
    assign entry    = {(count == 8'h00), stamp};

    always_ff @(posedge clk) begin
        if (reset) begin
            stamp <= '0;
            tc_q  <= 1'b0;
        end else begin
            stamp <= stamp + STAMP_ONE;
            tc_q  <= tc;
        end
    end

    // When full with a simultaneous pop the write slot aliases the head slot;
    // that is safe because the head is consumed on the same edge.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_cnt[AW-1:0]] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) wr_cnt <= wr_cnt + PTR_ONE;
            if (pop)  rd_cnt <= rd_cnt + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef TC_LOGGER_DROP_CNT_EN
    // A drop in the clearing cycle counts as the first drop after the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'h00;
        end else if (clr_ovf) begin
            drop_cnt <= drop ? 8'h01 : 8'h00;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_udcounter_tc_logger.sv
// Self-checking bench for udcounter_tc_logger: directed scenarios plus randomized
// traffic against a queue-based reference model of the event log.
module tb_udcounter_tc_logger;

    localparam int DEPTH   = 4;
    localparam int STAMP_W = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [7:0]          count = 8'h00;
    logic                tc = 1'b0;
    logic                clr_ovf = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [STAMP_W:0]    out_data;
    logic [2:0]          level;
    logic                overflow;
`ifdef TC_LOGGER_DROP_CNT_EN
    logic [7:0]          drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [STAMP_W:0]    exp_q[$];
    logic [STAMP_W-1:0]  m_stamp;
    logic                m_tc_q;
    logic                m_ovf;
    int                  m_drop;

    udcounter_tc_logger #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .count     (count),
        .tc        (tc),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
`ifdef TC_LOGGER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [STAMP_W:0] exp_head();
        return (exp_q.size() != 0) ? exp_q[0] : '0;
    endfunction

    function automatic logic [2:0] exp_level();
        return 3'(exp_q.size());
    endfunction

    // Advance one clock with the inputs currently driven; update the model from
    // the log rules and sample the DUT 1ns after the edge.
    task automatic step();
        logic ev, pop, push, drop;
        logic [STAMP_W:0] entry;
        if (reset) begin
            @(posedge clk); #1;
            exp_q.delete();
            m_stamp = '0; m_tc_q = 1'b0; m_ovf = 1'b0; m_drop = 0;
            return;
        end
        ev    = tc && !m_tc_q;
        pop   = (exp_q.size() != 0) && out_ready;
        push  = ev && ((exp_q.size() < DEPTH) || pop);
        drop  = ev && (exp_q.size() == DEPTH) && !pop;
        entry = {(count == 8'h00), m_stamp};
        @(posedge clk); #1;
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(entry);
        if (drop) m_ovf = 1'b1;
        else if (clr_ovf) m_ovf = 1'b0;
        if (clr_ovf) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < 255) m_drop++;
        m_tc_q  = tc;
        m_stamp = m_stamp + 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tc = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; count = 8'h00;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic pulse_event(input logic [7:0] cval);
        tc = 1'b1; count = cval; step();
        tc = 1'b0; step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (out_data !== 17'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
    endtask

    task automatic test_first_event();
        while (m_stamp != 16'd5) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL early_valid: got %b want 0", out_valid); end
        end
        tc = 1'b1; count = 8'hFF; step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== {1'b0, 16'd5}) begin errors++; $display("FAIL first_data: got %h want %h", out_data, {1'b0, 16'd5}); end
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL first_level: got %0d want 1", level); end
        tc = 1'b0; step();
    endtask

    task automatic test_hold();
        logic [15:0] rise;
        do_reset();
        repeat (3) step();
        rise = m_stamp;
        tc = 1'b1; count = 8'h00;
        repeat (10) step();
        checks++; if (level !== 3'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", level); end
        checks++; if (out_data !== {1'b1, rise}) begin errors++; $display("FAIL hold_data: got %h want %h", out_data, {1'b1, rise}); end
        tc = 1'b0; step();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) pulse_event((i % 2 == 0) ? 8'hFF : 8'h00);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
`ifdef TC_LOGGER_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL ovf_dropcnt: got %0d want 1", drop_cnt); end
`endif
        // head steady while not ready
        step();
        checks++; if (out_data !== exp_head()) begin errors++; $display("FAIL ovf_hold: got %h want %h", out_data, exp_head()); end
    endtask

    task automatic test_full_pop();
        logic [STAMP_W:0] second;
        second = exp_q[1];
        tc = 1'b1; count = 8'hFF; out_ready = 1'b1; step();
        tc = 1'b0; out_ready = 1'b0;
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d want 4", level); end
        checks++; if (out_data !== second) begin errors++; $display("FAIL fullpop_head: got %h want %h", out_data, second); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fullpop_ovf: got %b want 1", overflow); end
        // drain and verify order
        out_ready = 1'b1;
        while (exp_q.size() != 0) begin
            checks++; if (out_data !== exp_head()) begin errors++; $display("FAIL drain_data: got %h want %h", out_data, exp_head()); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        while (m_stamp != 16'hFFFF) step();
        tc = 1'b1; count = 8'h55; step();
        tc = 1'b0; step(); step();
        tc = 1'b1; step();
        tc = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL wrap_level: got %0d want 2", level); end
        checks++; if (out_data !== {1'b0, 16'hFFFF}) begin errors++; $display("FAIL wrap_first: got %h want %h", out_data, {1'b0, 16'hFFFF}); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_data !== {1'b0, 16'h0002}) begin errors++; $display("FAIL wrap_second: got %h want %h", out_data, {1'b0, 16'h0002}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) pulse_event(8'hFF);
        // clear with a simultaneous drop keeps overflow set
        tc = 1'b1; clr_ovf = 1'b1; step();
        tc = 1'b0; clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_drop_ovf: got %b want 1", overflow); end
`ifdef TC_LOGGER_DROP_CNT_EN
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL clr_drop_cnt: got %0d want 1", drop_cnt); end
`endif
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b want 0", overflow); end
        pulse_event(8'hFF);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level3: got %0d want 3", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL mid_ovf: got %b want 1", overflow); end
        reset = 1'b1; step(); reset = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL mid_level: got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) tc = ~tc;
            count     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF;
            out_ready = ($urandom_range(0, 3) == 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 199) == 0);
            step();
            reset = 1'b0;
            checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, exp_q.size() != 0); end
            checks++; if (level !== exp_level()) begin errors++; $display("FAIL rnd_level[%0d]: got %0d want %0d", i, level, exp_level()); end
            checks++; if (out_data !== exp_head()) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, out_data, exp_head()); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, overflow, m_ovf); end
`ifdef TC_LOGGER_DROP_CNT_EN
            checks++; if (drop_cnt !== 8'(m_drop)) begin errors++; $display("FAIL rnd_dropcnt[%0d]: got %0d want %0d", i, drop_cnt, m_drop); end
`endif
        end
        tc = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    endtask

    initial begin
        exp_q.delete();
        m_stamp = '0; m_tc_q = 1'b0; m_ovf = 1'b0; m_drop = 0;
        test_reset();
        test_first_event();
        test_hold();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
